// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO
// traffic source and checker.
package fifo_pkg;

  localparam int DSIZE = 8;
  localparam int ASIZE = 8;
  localparam int LEN_W = 10;

  typedef enum logic {
    INCR = 1'b0,
    LFSR = 1'b1
  } burst_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } writer_state_e;

  // x^8+x^6+x^5+x^4+1 as taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/burst_lfsr.sv
// Next-word generator: increment or LFSR step, or seed load.
// Ports: cur (current word), mode, load, seed -> nxt.
module burst_lfsr
  import fifo_pkg::*;
#(
  parameter int DSIZE = fifo_pkg::DSIZE
) (
  input  logic [DSIZE-1:0] cur,
  input  burst_mode_e      mode,
  input  logic             load,
  input  logic [DSIZE-1:0] seed,
  output logic [DSIZE-1:0] nxt
);

  logic [DSIZE-1:0] taps;
  logic [DSIZE-1:0] one;

  assign taps = DSIZE'(LFSR_TAPS);
  assign one  = DSIZE'(1);

  always_comb begin
    nxt = cur;
    unique case (1'b1)
      load: begin
        // all-zero is the LFSR lock-up state
        if (mode == LFSR && seed == '0)
          nxt = one;
        else
          nxt = seed;
      end
      (!load && mode == LFSR):
        nxt = {cur[DSIZE-2:0], ^(cur & taps)};
      (!load && mode == INCR):
        nxt = cur + one;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/fifo_burst_writer.sv
// Write-side burst source for the async FIFO.
// Ports: wclk/wrst, start+burst_len/gap/mode/seed,
// wfull -> winc/wdata, busy, done, wr_count.
module fifo_burst_writer
  import fifo_pkg::*;
#(
  parameter int DSIZE = fifo_pkg::DSIZE,
  parameter int LEN_W = fifo_pkg::LEN_W,
  parameter int GAP_W = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap,
  input  logic             mode,
  input  logic [DSIZE-1:0] seed,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] wr_count
);

  writer_state_e    state_q;
  writer_state_e    state_d;
  logic [LEN_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  burst_mode_e      mode_q;
  burst_mode_e      mode_sel;
  logic             accept;
  logic [LEN_W-1:0] cnt_inc;
  logic [DSIZE-1:0] data_nxt;

  assign accept   = (state_q == IDLE) && start;
  assign cnt_inc  = wr_count + 1'b1;
  assign mode_sel = accept ? burst_mode_e'(mode)
                           : mode_q;

  burst_lfsr #(.DSIZE(DSIZE)) u_gen (
    .cur  (wdata),
    .mode (mode_sel),
    .load (accept),
    .seed (seed),
    .nxt  (data_nxt)
  );

  always_comb begin
    state_d = state_q;
    winc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (burst_len == '0) ? DONE
                                      : WRITE;
      end
      WRITE: begin
        if (!wfull) begin
          winc = 1'b1;
          if (cnt_inc == len_q)
            state_d = DONE;
          else if (gap_q != '0)
            state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q <= GAP_W'(1))
          state_d = WRITE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      mode_q    <= INCR;
      wdata     <= '0;
      wr_count  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q    <= burst_len;
        gap_q    <= gap;
        mode_q   <= burst_mode_e'(mode);
        wdata    <= data_nxt;
        wr_count <= '0;
      end else if (winc) begin
        wdata     <= data_nxt;
        wr_count  <= cnt_inc;
        gap_cnt_q <= gap_q;
      end else if (state_q == GAP) begin
        gap_cnt_q <= gap_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_burst_writer.md
# fifo_burst_writer

Write-side traffic source for the asynchronous FIFO: on a start pulse it pushes a burst of `burst_len` words into the FIFO write port, honouring `wfull` and inserting a programmable idle gap between writes. It runs entirely in the write clock domain and drives `winc`/`wdata` of the FIFO directly. Each burst is either an incrementing count or an LFSR sequence, so the read-side checker can predict every word.

## Interface
- `DSIZE`, 8, data width; must match the FIFO.
- `LEN_W`, 10, burst length counter width; covers bursts up to 1023 words, including the standard 512-word burst.
- `GAP_W`, 4, idle-gap field width.

- `wclk`  in  1  write clock; all logic is on its rising edge.
- `wrst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle burst request; sampled only in IDLE.
- `burst_len`  in  LEN_W  number of words; sampled with `start`.
- `gap`  in  GAP_W  idle cycles after each accepted write; sampled with `start`.
- `mode`  in  1  0 = incrementing, 1 = LFSR; sampled with `start`.
- `seed`  in  DSIZE  first data word; sampled with `start`.
- `wfull`  in  1  FIFO full flag, in the wclk domain.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `wr_count`  out  LEN_W  writes accepted in the current or last burst.

## Operation
- States:
  - IDLE. Start here.
  - WRITE. Enter from IDLE on `start` with `burst_len`≠0.
  - GAP. Enter from WRITE after an accepted write when `gap`≠0 and words remain.
  - DONE. Enter from WRITE after the last write, or from IDLE on `start` with `burst_len`=0.
  - DONE always returns to IDLE after one cycle.
- On an accepted `start`:
  - Latch `burst_len`, `gap` and `mode`.
  - Load `wdata` with `seed`. In LFSR mode, seed 0 is replaced by 8'h01.
  - Clear `wr_count`.
- `winc` = (state==WRITE) && !`wfull`. It is combinational, so it never asserts while full.
- On an accepted write (`winc`=1):
  - `wr_count` increments.
  - `wdata` advances to the next value.
    - Incrementing mode: +1 modulo 2^DSIZE, so 8'hFF wraps to 8'h00.
    - LFSR mode: Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
- When `wfull`=1 in WRITE, the block stays in WRITE. `wdata` and `wr_count` hold.
- GAP counts down `gap` cycles, then returns to WRITE. `wfull` has no effect in GAP.
- `start` in any state other than IDLE is ignored.
- `done` is high exactly in DONE. `busy` is high in WRITE, GAP and DONE.

## Timing
- Reset values: state IDLE, `winc` 0, `wdata` 0, `busy` 0, `done` 0, `wr_count` 0.
- `start` at edge N: `winc` can be high in cycle N+1.
- `gap`=0 with `wfull` low: one write per cycle. A burst of L words occupies cycles N+1..N+L, and `done` is high in cycle N+L+1.
- `gap`=G: consecutive accepted writes are spaced G+1 cycles apart when not full.
- `wfull` rising in the same cycle as a pending write: that write is suppressed and retried the first cycle `wfull` is low.
- Reset asserted mid-burst: all outputs return to reset values at that edge. No `done` pulse; the burst is abandoned.
- `wr_count` keeps the last burst value until the next accepted `start`.

## Structure
- Shared package `fifo_pkg` holds:
  - `DSIZE` and `ASIZE` defaults (8/8).
  - `LEN_W`.
  - The `burst_mode_e` enum (INCR, LFSR).
  - The `writer_state_e` enum (IDLE, WRITE, GAP, DONE).
  - The LFSR tap mask constant 8'hB8.
- Sub-module `burst_lfsr`: next-value generator selecting between increment and LFSR step, with a load-seed input. It is reused by the read-side checker for prediction.

## Test plan
- Reset, then `start`, `burst_len`=4, `gap`=0, INCR, `seed`=8'h10, `wfull`=0 -> `winc` high 4 consecutive cycles with `wdata` 10,11,12,13; `done` one cycle later; `wr_count`=4.
- INCR, `seed`=8'hFE, `burst_len`=3 -> `wdata` FE, FF, 00.
- LFSR, `seed`=0, `burst_len`=3 -> `wdata` 01, 02, 04.
- `burst_len`=6, `gap`=2, `wfull` forced high for cycles 3–7 ->
  - `winc` never high while `wfull`=1.
  - No word skipped or duplicated.
  - `wr_count`=6 at `done`.
- `burst_len`=0 -> no `winc`; `done` one cycle after `start`. A second `start` while `busy` is ignored.
- `wrst` asserted after 200 of 512 writes -> `winc` and `busy` low at the next edge, no `done`. A fresh 512-word burst then completes normally.
